// File: rtl/serial_bla_subtractor.sv
// ---------------------------------------------------------------------------
// serial_bla_subtractor
//
// Purpose:
//   Multi-cycle subtractor computing diff = a - b - bin (mod 2^WIDTH) one
//   4-bit nibble per clock, least-significant nibble first. Each nibble slice
//   resolves its four internal borrows in flat borrow-lookahead form. The
//   borrow out of a slice is registered and feeds the next nibble on the
//   following clock. This is the subtract-direction companion of the 4-bit
//   carry-lookahead adder. Valid/ready handshakes on both sides let it sit in
//   a datapath pipeline.
//
// Parameters:
//   WIDTH     operand/result width in bits. Must be a multiple of 4 and >= 4.
//   NIB       WIDTH/4 nibble steps. Derived; cannot be overridden.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present on a/b/bin
//   in_ready   block can accept operands (high only while idle)
//   a, b, bin  minuend, subtrahend, borrow-in (sampled on the accept edge only)
//   out_valid  result available (high only while holding a result)
//   out_ready  consumer accepts the result
//   diff       a - b - bin modulo 2^WIDTH
//   bout       final borrow, 1 iff a < b + bin (unsigned)
//   ovf        (only with SERIAL_SUB_OVF_EN) signed two's-complement overflow
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the ovf output and its register.
//
// Timing:
//   An accept on edge k raises out_valid after edge k+NIB. A new operand set
//   can be accepted no earlier than the edge after the output handshake, so
//   the minimum issue interval is NIB+2 cycles.
// ---------------------------------------------------------------------------
module serial_bla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // One nibble of borrow-lookahead subtraction.
    // Per bit: t = x^y, gb = ~x&y (borrow generate), pb = ~t (borrow
    // propagate). Every borrow is written directly in terms of gb/pb and the
    // incoming borrow so no borrow waits on its neighbour.
    // Returns {borrow_out, difference[3:0]}.
    // -----------------------------------------------------------------------
    function automatic logic [4:0] bla_nibble(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       bi
    );
        logic [3:0] t;
        logic [3:0] gb;
        logic [3:0] pb;
        logic [4:0] br;
        t     = x ^ y;
        gb    = ~x & y;
        pb    = ~t;
        br[0] = bi;
        br[1] = gb[0]
              | (pb[0] & bi);
        br[2] = gb[1]
              | (pb[1] & gb[0])
              | (pb[1] & pb[0] & bi);
        br[3] = gb[2]
              | (pb[2] & gb[1])
              | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & bi);
        br[4] = gb[3]
              | (pb[3] & gb[2])
              | (pb[3] & pb[2] & gb[1])
              | (pb[3] & pb[2] & pb[1] & gb[0])
              | (pb[3] & pb[2] & pb[1] & pb[0] & bi);
        return {br[4], t ^ br[3:0]};
    endfunction

    // State and registered outputs
    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  diff_r;
    logic              bout_r;

    // Operand shadows, nibble index, inter-nibble borrow
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [IDXW-1:0]   idx_r;
    logic              brw_r;

    // Current nibble slice
    logic [3:0]        a_nib_s;
    logic [3:0]        b_nib_s;
    logic [4:0]        slice_s;
    logic [WIDTH-1:0]  nib_mask_s;
    logic [WIDTH-1:0]  nib_ins_s;
    logic              accept_s;
    logic              last_nib_s;

`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_r;
    logic              ovf_nxt_s;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_r;
`endif

    // Select the active nibble, run the lookahead slice, and build the
    // mask/insert pair that writes the slice result into the result register.
    always_comb begin
        a_nib_s    = 4'(a_r >> {idx_r, 2'b00});
        b_nib_s    = 4'(b_r >> {idx_r, 2'b00});
        slice_s    = bla_nibble(a_nib_s, b_nib_s, brw_r);
        nib_mask_s = WIDTH'(4'hF) << {idx_r, 2'b00};
        nib_ins_s  = WIDTH'(slice_s[3:0]) << {idx_r, 2'b00};
        accept_s   = in_valid & in_ready_r;
        last_nib_s = (idx_r == LAST_IDX);
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: operand signs differ and the result sign differs from
    // the minuend. Only used on the last nibble, where slice bit 3 is the MSB.
    always_comb begin
        ovf_nxt_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (slice_s[3] ^ a_r[WIDTH-1]);
    end
`endif

    // Next-state logic for the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_nib_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus handshake flags registered from the next state so
    // in_ready/out_valid come straight off flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Datapath: operand capture on accept, one nibble per RUN cycle, result
    // held through DONE and kept after the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            idx_r  <= {IDXW{1'b0}};
            brw_r  <= 1'b0;
            diff_r <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r   <= a;
                        b_r   <= b;
                        brw_r <= bin;
                        idx_r <= {IDXW{1'b0}};
                    end
                end
                RUN: begin
                    diff_r <= (diff_r & ~nib_mask_s) | nib_ins_s;
                    brw_r  <= slice_s[4];
                    idx_r  <= idx_r + IDXW'(1);
                    if (last_nib_s) begin
                        bout_r <= slice_s[4];
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r  <= ovf_nxt_s;
`endif
                    end
                end
                DONE: begin
                    // Result registers hold; nothing to update.
                end
                default: begin
                    idx_r <= {IDXW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bla_subtractor.sv
`timescale 1ns/1ps
module tb_serial_bla_subtractor;

    localparam int W  = 16;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic          rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [W-1:0]  a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf;
`endif

    // 8-bit instance
    logic          rst8_n, iv8, ir8, bin8, ov8, or8, bo8;
    logic [W8-1:0] a8, b8, d8;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf8;
`endif

    int   checks = 0;
    int   errors = 0;
    logic done8  = 1'b0;

    logic [17:0] q16[$];   // {ovf, bout, diff}
    logic [9:0]  q8[$];    // {ovf, bout, diff}

    serial_bla_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf),
`endif
        .bout(bout)
    );

    serial_bla_subtractor #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8),
        .diff(d8),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf8),
`endif
        .bout(bo8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: widened subtraction gives {bout, diff}; ovf from sign rules.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic [16:0] r;
        r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        return {(x[15] != y[15]) && (r[15] != x[15]), r};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] r;
        r = {1'b0, x} - {1'b0, y} - {8'd0, bi};
        return {(x[7] != y[7]) && (r[7] != x[7]), r};
    endfunction

    // Output monitor, 16-bit: compares every cycle out_valid is high, so a
    // stalled result is also checked for stability.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q16.size() == 0) begin
                chk("valid_without_accept16", {31'd0, out_valid}, 32'd0);
            end else if (out_valid) begin
                chk("diff16", {16'd0, diff}, {16'd0, q16[0][15:0]});
                chk("bout16", {31'd0, bout}, {31'd0, q16[0][16]});
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf16", {31'd0, ovf}, {31'd0, q16[0][17]});
`endif
                if (out_ready) void'(q16.pop_front());
            end
        end
    end

    // Output monitor, 8-bit.
    always @(negedge clk) begin
        if (rst8_n === 1'b1) begin
            if (q8.size() == 0) begin
                chk("valid_without_accept8", {31'd0, ov8}, 32'd0);
            end else if (ov8) begin
                chk("diff8", {24'd0, d8}, {24'd0, q8[0][7:0]});
                chk("bout8", {31'd0, bo8}, {31'd0, q8[0][8]});
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf8", {31'd0, ovf8}, {31'd0, q8[0][9]});
`endif
                if (or8) void'(q8.pop_front());
            end
        end
    end

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic bi);
        a = x; b = y; bin = bi; in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q16.push_back(model16(x, y, bi));
    endtask

    task automatic wait_out16(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic xact16(input logic [15:0] x, input logic [15:0] y, input logic bi, input int stalls);
        int lat;
        out_ready = (stalls == 0);
        send16(x, y, bi);
        wait_out16(lat);
        chk("latency", lat, 32'd4);
        repeat (stalls) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    // 8-bit random regression with random output stalls.
    initial begin
        int n;
        rst8_n = 1'b0; iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0; or8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst8_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); iv8 = 1'b1;
            n = 0;
            while (!ir8 && n < 64) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            iv8 = 1'b0;
            q8.push_back(model8(a8, b8, bin8));
            n = 0;
            do begin
                or8 = 1'($urandom);
                @(posedge clk); #1;
                n++;
            end while (!ir8 && n < 200);
            chk("t8_done", {31'd0, ir8}, 32'd1);
        end
        done8 = 1'b1;
    end

    // 16-bit directed and random sequence.
    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; a = 16'd0; b = 16'd0; bin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      {16'd0, diff},      32'd0);
        chk("rst_bout",      {31'd0, bout},      32'd0);

        // Basic, borrow-out, borrow-in and equal-operand boundaries
        xact16(16'h1234, 16'h0234, 1'b0, 0);
        xact16(16'h0000, 16'h0001, 1'b0, 0);
        xact16(16'h0005, 16'h0005, 1'b1, 0);
        xact16(16'hAAAA, 16'hAAAA, 1'b0, 1);
        xact16(16'h0000, 16'hFFFF, 1'b1, 2);
        // Signed overflow cases
        xact16(16'h8000, 16'h0001, 1'b0, 0);
        xact16(16'h7FFF, 16'hFFFF, 1'b0, 0);
        xact16(16'h0003, 16'h0001, 1'b0, 0);

        // Backpressure with garbage on the inputs after accept
        out_ready = 1'b0;
        send16(16'hABCD, 16'h1111, 1'b0);
        lat = 0;
        while (!out_valid && lat < 64) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 32'd4);
        repeat (5) begin
            a = 16'($urandom); b = 16'($urandom);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", {31'd0, in_ready},  32'd1);
        chk("bp_out_valid_low",  {31'd0, out_valid}, 32'd0);
        chk("bp_diff_kept",      {16'd0, diff},      32'h9ABC);
        chk("bp_bout_kept",      {31'd0, bout},      32'd0);

        // Reset while the third nibble is being processed
        send16(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q16.delete();
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_diff",      {16'd0, diff},      32'd0);
        chk("abort_bout",      {31'd0, bout},      32'd0);
        xact16(16'h0010, 16'h0001, 1'b0, 0);

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            xact16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        for (int n = 0; n < 60000 && !done8; n++) @(posedge clk);
        chk("t8_finished", {31'd0, done8}, 32'd1);
        chk("q16_drained", q16.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
